// File: rtl/ppr_reduce.sv
// Registered 4:2 compressor row for the 8x8 Booth multiplier: folds four partial products
// and three sign-extension bits into 13-bit sum/carry vectors, one cycle of latency.
module ppr_reduce (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [8:0]  pp0,
  input  logic [8:0]  pp1,
  input  logic [8:0]  pp2,
  input  logic [8:0]  pp3,
  input  logic        sign0,
  input  logic        sign1,
  input  logic        sign2,
  output logic [12:0] sum,
  output logic [12:0] carry,
  output logic        out_valid
);

  logic [12:0] col_i1, col_i2, col_i3, col_i4;
  logic [12:0] col_t;
  logic [13:0] chain;
  logic [12:0] sum_d, sum_q;
  logic [12:0] carry_d, carry_q;
  logic        out_valid_d, out_valid_q;

  // Column k of each vector is the k-th input of compressor k; pp0[1:0] never reach a column.
  always_comb begin
    col_i1 = {{6{sign0}}, pp0[8:2]};
    col_i2 = {{4{sign1}}, pp1};
    col_i3 = {{2{sign2}}, pp2, 2'b00};
    col_i4 = {pp3, 4'b0000};
  end

  always_comb begin
    chain    = '0;
    col_t    = '0;
    sum_d    = '0;
    carry_d  = '0;
    chain[0] = 1'b0;
    for (int k = 0; k < 13; k++) begin
      col_t[k]     = col_i1[k] ^ col_i2[k] ^ col_i3[k];
      chain[k+1]   = (col_i1[k] & col_i2[k]) | (col_i1[k] & col_i3[k]) |
                     (col_i2[k] & col_i3[k]);
      sum_d[k]     = col_t[k] ^ chain[k] ^ col_i4[k];
      carry_d[k]   = (col_t[k] & (chain[k] ^ col_i4[k])) | (chain[k] & col_i4[k]);
    end
    out_valid_d = in_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q       <= '0;
      carry_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_ppr_reduce.sv
// Self-checking bench for ppr_reduce: directed vectors, an exhaustive sweep and random
// vectors, all compared against an arithmetic column model.
module tb_ppr_reduce;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [8:0]  pp0, pp1, pp2, pp3;
  logic        sign0, sign1, sign2;
  logic [12:0] sum, carry;
  logic        out_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ppr_reduce u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .pp0       (pp0),
    .pp1       (pp1),
    .pp2       (pp2),
    .pp3       (pp3),
    .sign0     (sign0),
    .sign1     (sign1),
    .sign2     (sign2),
    .sum       (sum),
    .carry     (carry),
    .out_valid (out_valid)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Column input as an integer 0/1, from the reduction table.
  function automatic int col_in(input int k, input int which, input logic [8:0] a,
                                input logic [8:0] b, input logic [8:0] c, input logic [8:0] d,
                                input logic s0, input logic s1, input logic s2);
    case (which)
      1: return (k <= 6) ? int'(a[k+2]) : int'(s0);
      2: return (k <= 8) ? int'(b[k]) : int'(s1);
      3: return (k < 2) ? 0 : ((k <= 10) ? int'(c[k-2]) : int'(s2));
      default: return (k < 4) ? 0 : int'(d[k-4]);
    endcase
  endfunction

  // Returns {cout12, carry, sum}: each column splits its bit count into sum + 2*(c + cout).
  function automatic logic [26:0] model(input logic [8:0] a, input logic [8:0] b,
                                        input logic [8:0] c, input logic [8:0] d,
                                        input logic s0, input logic s1, input logic s2);
    logic [12:0] s, cy;
    int cin, trio, cout, rem;
    cin = 0;
    s = '0;
    cy = '0;
    for (int k = 0; k < 13; k++) begin
      trio  = col_in(k, 1, a, b, c, d, s0, s1, s2) + col_in(k, 2, a, b, c, d, s0, s1, s2) +
              col_in(k, 3, a, b, c, d, s0, s1, s2);
      cout  = (trio >= 2) ? 1 : 0;
      rem   = trio - 2 * cout + cin + col_in(k, 4, a, b, c, d, s0, s1, s2);
      s[k]  = rem[0];
      cy[k] = rem[1];
      cin   = cout;
    end
    return {cin[0], cy, s};
  endfunction

  function automatic int weighted(input logic [8:0] a, input logic [8:0] b,
                                  input logic [8:0] c, input logic [8:0] d,
                                  input logic s0, input logic s1, input logic s2);
    int acc;
    acc = 0;
    for (int k = 0; k < 13; k++)
      for (int w = 1; w <= 4; w++)
        acc += col_in(k, w, a, b, c, d, s0, s1, s2) << k;
    return acc;
  endfunction

  task automatic drive(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c,
                       input logic [8:0] d, input logic s0, input logic s1, input logic s2,
                       input logic v);
    pp0 = a; pp1 = b; pp2 = c; pp3 = d;
    sign0 = s0; sign1 = s1; sign2 = s2;
    in_valid = v;
  endtask

  // Clock the current inputs in and check the registered result against the model.
  task automatic step_check(input string tag);
    logic [26:0] exp;
    int          wsum;
    logic        v;
    exp  = model(pp0, pp1, pp2, pp3, sign0, sign1, sign2);
    wsum = weighted(pp0, pp1, pp2, pp3, sign0, sign1, sign2);
    v    = in_valid;
    @(posedge clk);
    #1;
    check_val({tag, "_sum"}, 32'(sum), 32'(exp[12:0]));
    check_val({tag, "_carry"}, 32'(carry), 32'(exp[25:13]));
    check_val({tag, "_vld"}, 32'(out_valid), 32'(v));
    check_val({tag, "_inv"}, 32'((32'(sum) + 2 * 32'(carry)) & 32'h1fff),
              32'(wsum & 32'h1fff));
  endtask

  task automatic directed(input string tag, input logic [8:0] a, input logic [8:0] b,
                          input logic [8:0] c, input logic [8:0] d, input logic s0,
                          input logic s1, input logic s2, input logic [12:0] es,
                          input logic [12:0] ec);
    drive(a, b, c, d, s0, s1, s2, 1'b1);
    @(posedge clk);
    #1;
    check_val({tag, "_sum"}, 32'(sum), 32'(es));
    check_val({tag, "_carry"}, 32'(carry), 32'(ec));
  endtask

  initial begin
    logic [9:0] f;
    logic [8:0] a, c;

    // Reset with random data present.
    reset = 1'b1;
    drive(9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom), 1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    check_val("rst_sum", 32'(sum), 32'h0);
    check_val("rst_carry", 32'(carry), 32'h0);
    check_val("rst_vld", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    check_val("rst_hold_sum", 32'(sum), 32'h0);
    check_val("rst_hold_vld", 32'(out_valid), 32'h0);

    directed("single", 9'h004, 9'h000, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 13'h0001, 13'h0000);
    directed("ripple", 9'h004, 9'h001, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 13'h0002, 13'h0000);
    directed("signext", 9'h000, 9'h000, 9'h000, 9'h000, 1'b1, 1'b1, 1'b1, 13'h0580, 13'h1800);
    directed("col4", 9'h040, 9'h010, 9'h004, 9'h001, 1'b0, 1'b0, 1'b0, 13'h0020, 13'h0010);
    directed("pp3_ones", 9'h000, 9'h000, 9'h000, 9'h1ff, 1'b0, 1'b0, 1'b0, 13'h1ff0, 13'h0000);
    directed("pp0_low", 9'h003, 9'h000, 9'h000, 9'h000, 1'b0, 1'b0, 1'b0, 13'h0000, 13'h0000);

    // Mid-stream reset discards the in-flight result.
    drive(9'h1ff, 9'h1ff, 9'h1ff, 9'h1ff, 1'b1, 1'b1, 1'b1, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("midrst_sum", 32'(sum), 32'h0);
    check_val("midrst_carry", 32'(carry), 32'h0);
    check_val("midrst_vld", 32'(out_valid), 32'h0);

    // Exhaustive sweep of the ten varying bits, one vector per cycle.
    for (int n = 0; n < 1024; n++) begin
      f = 10'(n);
      a = 9'b0_1000_0000;
      a[0] = f[0]; a[2] = f[1]; a[4] = f[2]; a[6] = f[3]; a[8] = f[4];
      c = 9'b0_1010_1010;
      c[0] = f[6]; c[2] = f[7]; c[4] = f[8]; c[6] = f[9];
      drive(a, 9'h012, c, 9'h012, f[5], 1'b0, 1'b1, 1'($urandom));
      step_check("sweep");
    end

    for (int n = 0; n < 300; n++) begin
      drive(9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom));
      step_check("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
